// File: rtl/ioctl_loader_pkg.sv
// Shared types and constants for the ioctl ROM loader: FSM states, stream
// indices, machine-select codes and a saturating counter helper.
package ioctl_loader_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      HOLD = 2'd2,
      RUN  = 2'd3
   } state_e;

   localparam logic [7:0] IDX_ROM = 8'd0;
   localparam logic [7:0] IDX_MOD = 8'd1;
   localparam logic [7:0] IDX_DIP = 8'd254;

   localparam logic [7:0] MOD_BWIDOW   = 8'd0;
   localparam logic [7:0] MOD_GRAVITAR = 8'd1;
   localparam logic [7:0] MOD_LUNARBAT = 8'd2;
   localparam logic [7:0] MOD_SPACDUEL = 8'd3;

   function automatic logic [16:0] sat_inc17(input logic [16:0] v);
      logic [16:0] r;
      if (v == 17'h1FFFF) begin
         r = v;
      end else begin
         r = v + 17'd1;
      end
      return r;
   endfunction

endpackage

// File: rtl/ioctl_edge_det.sv
// Rise/fall detector: compares a level against its registered copy from the
// previous clk cycle.
module ioctl_edge_det
   import ioctl_loader_pkg::*;
(
   input  logic clk_i,
   input  logic reset_i,
   input  logic level_i,
   output logic rise_o,
   output logic fall_o
);

   logic level_q;

   // Previous-cycle copy of the level.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         level_q <= 1'b0;
      end else begin
         level_q <= level_i;
      end
   end

   assign rise_o = level_i & ~level_q;
   assign fall_o = ~level_i & level_q;

endmodule

// File: rtl/ioctl_rom_loader.sv
// Demultiplexes the hps_io ioctl stream into ROM writes, machine select and
// DIP bank, and owns the core reset. Optional checksum: IOCTL_ROM_LOADER_CHECKSUM_EN.
module ioctl_rom_loader
   import ioctl_loader_pkg::*;
#(
   parameter logic [16:0] ROM_SIZE    = 17'h10000,
   parameter int          HOLD_CYCLES = 16,
   parameter logic [7:0]  DIP_DEFAULT = 8'h00
) (
   input  logic        clk_12,
   input  logic        reset,
   input  logic        ioctl_download,
   input  logic        ioctl_wr,
   input  logic [24:0] ioctl_addr,
   input  logic [7:0]  ioctl_dout,
   input  logic [7:0]  ioctl_index,
   output logic        dn_wr,
   output logic [15:0] dn_addr,
   output logic [7:0]  dn_data,
   output logic        mod_bwidow,
   output logic        mod_gravitar,
   output logic        mod_lunarbat,
   output logic        mod_spacduel,
   output logic [63:0] dip_sw,
   output logic        core_reset,
   output logic        rom_loaded,
   output logic        rom_overflow,
   output logic [16:0] byte_count,
   output logic [15:0] rom_sum
);

   localparam logic [15:0] HOLD_LOAD = 16'(HOLD_CYCLES - 1);

   logic rom_dl_s, dl_start_s, dl_end_s;
   logic in_range_s, accept_s, oob_s;
   logic dip_wr_s, mod_wr_s;

   logic        dn_wr_q;
   logic [15:0] dn_addr_q;
   logic [7:0]  dn_data_q;
   logic [16:0] byte_count_q, byte_count_d;
   logic        rom_overflow_q, rom_overflow_d;
   logic [7:0]  mod_q;
   logic [3:0]  mod_dec_q;
   logic [63:0] dip_q;
   state_e      state_q;
   logic [15:0] hold_cnt_q;
   logic        core_reset_q, rom_loaded_q;

   assign rom_dl_s   = ioctl_download & (ioctl_index == IDX_ROM);
   assign in_range_s = (ioctl_addr < {8'h00, ROM_SIZE});
   assign accept_s   = ioctl_wr & rom_dl_s & in_range_s;
   assign oob_s      = ioctl_wr & rom_dl_s & ~in_range_s;
   assign mod_wr_s   = ioctl_wr & (ioctl_index == IDX_MOD);
   assign dip_wr_s   = ioctl_wr & (ioctl_index == IDX_DIP) & (ioctl_addr[24:3] == 22'd0);

   ioctl_edge_det u_dl_edge (
      .clk_i   (clk_12),
      .reset_i (reset),
      .level_i (rom_dl_s),
      .rise_o  (dl_start_s),
      .fall_o  (dl_end_s)
   );

   // Per-download statistics: a dl_start clears first, a same-cycle byte then counts.
   always_comb begin
      byte_count_d   = dl_start_s ? 17'd0 : byte_count_q;
      rom_overflow_d = dl_start_s ? 1'b0 : rom_overflow_q;
      if (accept_s) begin
         byte_count_d = sat_inc17(byte_count_d);
      end else begin
         byte_count_d = byte_count_d;
      end
      if (oob_s) begin
         rom_overflow_d = 1'b1;
      end else begin
         rom_overflow_d = rom_overflow_d;
      end
   end

   // ROM write stream and download statistics registers.
   always_ff @(posedge clk_12) begin
      if (reset) begin
         dn_wr_q        <= 1'b0;
         dn_addr_q      <= 16'h0000;
         dn_data_q      <= 8'h00;
         byte_count_q   <= 17'd0;
         rom_overflow_q <= 1'b0;
      end else begin
         dn_wr_q        <= accept_s;
         byte_count_q   <= byte_count_d;
         rom_overflow_q <= rom_overflow_d;
         if (accept_s) begin
            dn_addr_q <= ioctl_addr[15:0];
            dn_data_q <= ioctl_dout;
         end
      end
   end

`ifdef IOCTL_ROM_LOADER_CHECKSUM_EN
   logic [15:0] rom_sum_q, rom_sum_d;

   // Checksum next value: cleared on dl_start, then the accepted byte is added.
   always_comb begin
      rom_sum_d = dl_start_s ? 16'h0000 : rom_sum_q;
      if (accept_s) begin
         rom_sum_d = rom_sum_d + {8'h00, ioctl_dout};
      end else begin
         rom_sum_d = rom_sum_d;
      end
   end

   // Checksum register.
   always_ff @(posedge clk_12) begin
      if (reset) begin
         rom_sum_q <= 16'h0000;
      end else begin
         rom_sum_q <= rom_sum_d;
      end
   end

   assign rom_sum = rom_sum_q;
`else
   assign rom_sum = 16'h0000;
`endif

   // Machine-select latch and its registered one-hot decode (unknown codes give all zero).
   always_ff @(posedge clk_12) begin
      if (reset) begin
         mod_q     <= MOD_BWIDOW;
         mod_dec_q <= 4'b0001;
      end else begin
         if (mod_wr_s) begin
            mod_q <= ioctl_dout;
         end
         mod_dec_q <= {mod_q == MOD_SPACDUEL, mod_q == MOD_LUNARBAT,
                       mod_q == MOD_GRAVITAR, mod_q == MOD_BWIDOW};
      end
   end

   // DIP bank: eight bytes, writable in any state.
   always_ff @(posedge clk_12) begin
      if (reset) begin
         dip_q <= {8{DIP_DEFAULT}};
      end else if (dip_wr_s) begin
         dip_q[{ioctl_addr[2:0], 3'b000} +: 8] <= ioctl_dout;
      end
   end

   // Download / core-reset state machine; core_reset is low only in RUN.
   always_ff @(posedge clk_12) begin
      if (reset) begin
         state_q      <= IDLE;
         hold_cnt_q   <= 16'h0000;
         core_reset_q <= 1'b1;
         rom_loaded_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               core_reset_q <= 1'b1;
               if (dl_start_s) begin
                  state_q <= LOAD;
               end
            end
            LOAD: begin
               core_reset_q <= 1'b1;
               if (dl_end_s) begin
                  if (byte_count_q != 17'd0) begin
                     state_q      <= HOLD;
                     hold_cnt_q   <= HOLD_LOAD;
                     rom_loaded_q <= 1'b1;
                  end else if (rom_loaded_q) begin
                     state_q    <= HOLD;
                     hold_cnt_q <= HOLD_LOAD;
                  end else begin
                     state_q <= IDLE;
                  end
               end
            end
            HOLD: begin
               if (dl_start_s) begin
                  state_q      <= LOAD;
                  core_reset_q <= 1'b1;
               end else if (hold_cnt_q == 16'h0000) begin
                  state_q      <= RUN;
                  core_reset_q <= 1'b0;
               end else begin
                  hold_cnt_q   <= hold_cnt_q - 16'h0001;
                  core_reset_q <= 1'b1;
               end
            end
            RUN: begin
               if (dl_start_s) begin
                  state_q      <= LOAD;
                  core_reset_q <= 1'b1;
               end else begin
                  core_reset_q <= 1'b0;
               end
            end
            default: begin
               state_q      <= IDLE;
               core_reset_q <= 1'b1;
            end
         endcase
      end
   end

   assign dn_wr        = dn_wr_q;
   assign dn_addr      = dn_addr_q;
   assign dn_data      = dn_data_q;
   assign mod_bwidow   = mod_dec_q[0];
   assign mod_gravitar = mod_dec_q[1];
   assign mod_lunarbat = mod_dec_q[2];
   assign mod_spacduel = mod_dec_q[3];
   assign dip_sw       = dip_q;
   assign core_reset   = core_reset_q;
   assign rom_loaded   = rom_loaded_q;
   assign rom_overflow = rom_overflow_q;
   assign byte_count   = byte_count_q;

endmodule
